// File: rtl/array_check_pkg.sv
// Package shared by the array order checker.
// Holds the controller state encoding and the bit positions inside the 2-bit mode field.
package array_check_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      SCAN,
      DONE
   } state_t;

   localparam int unsigned MODE_DESC_BIT   = 0;
   localparam int unsigned MODE_STRICT_BIT = 1;

endpackage

// File: rtl/order_compare.sv
// Combinational pair comparator for the array order checker.
// Flags whether the pair (prev, cur) violates the selected ordering.
// Ports:
//   prev     - earlier element of the pair
//   cur      - later element of the pair
//   mode     - bit MODE_DESC_BIT = descending, bit MODE_STRICT_BIT = strict
//   inverted - 1 when the pair is out of order
// Parameters: DATA_W element width, SIGNED = 1 compares as two's complement.
module order_compare
   import array_check_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned SIGNED = 0
) (
   input  logic [DATA_W-1:0] prev,
   input  logic [DATA_W-1:0] cur,
   input  logic [1:0]        mode,
   output logic              inverted
);

   logic gt;
   logic eq;
   logic lt;
   logic desc;
   logic strict;

   always_comb begin
      if (SIGNED != 0) begin
         gt = $signed(prev) > $signed(cur);
      end else begin
         gt = prev > cur;
      end
      eq     = (prev == cur);
      lt     = !gt && !eq;
      desc   = mode[MODE_DESC_BIT];
      strict = mode[MODE_STRICT_BIT];
      // Strict orderings also reject equal neighbours.
      if (desc) begin
         inverted = lt || (strict && eq);
      end else begin
         inverted = gt || (strict && eq);
      end
   end

endmodule

// File: rtl/array_order_check.sv
// Array order checker: controller plus streaming datapath.
// Scans `length` words from a synchronous-read memory starting at `base_addr` and checks each
// adjacent pair against the ordering selected by `mode`.
// Ports:
//   clock, reset         - posedge clock, asynchronous active-low reset
//   go                   - start request, accepted only in IDLE or DONE
//   base_addr/length/mode- scan setup, latched on an accepted go
//   mem_addr, rd_data    - memory read port, data returns one cycle after the address
//   busy                 - high in PRIME and SCAN
//   done, sorted         - verdict, sticky until the next go
//   inv_index            - index of the second element of the first inverted pair (0 if sorted)
//   inv_count            - number of inverted pairs (only with ARRAY_ORDER_COUNT_EN)
// Optional feature macro: ARRAY_ORDER_COUNT_EN (full scan with inversion counting).
module array_order_check
   import array_check_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned LEN_W  = 11,
   parameter int unsigned SIGNED = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              go,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic [1:0]        mode,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              sorted,
   output logic [LEN_W-1:0]  inv_index
`ifdef ARRAY_ORDER_COUNT_EN
   ,
   output logic [LEN_W-1:0]  inv_count
`endif
);

   localparam logic [ADDR_W-1:0] AddrOne = 1;
   localparam logic [LEN_W-1:0]  LenOne  = 1;
   localparam logic [LEN_W-1:0]  LenTwo  = 2;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [1:0]          mode_q, mode_d;
   logic [DATA_W-1:0]   prev_q, prev_d;
   logic [LEN_W-1:0]    idx_q, idx_d;
   logic                sorted_q, sorted_d;
   logic [LEN_W-1:0]    inv_index_q, inv_index_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                inverted;
   logic                last_pair;
`ifdef ARRAY_ORDER_COUNT_EN
   logic [LEN_W-1:0]    count_q, count_d;
`endif

   order_compare #(
      .DATA_W (DATA_W),
      .SIGNED (SIGNED)
   ) u_compare (
      .prev     (prev_q),
      .cur      (rd_data),
      .mode     (mode_q),
      .inverted (inverted)
   );

   assign last_pair = (idx_q == len_q - LenOne);

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      len_d       = len_q;
      mode_d      = mode_q;
      prev_d      = prev_q;
      idx_d       = idx_q;
      sorted_d    = sorted_q;
      inv_index_d = inv_index_q;
      addr_d      = addr_q;
`ifdef ARRAY_ORDER_COUNT_EN
      count_d     = count_q;
`endif
      unique case (state_q)
         IDLE, DONE: begin
            if (go) begin
               base_d      = base_addr;
               len_d       = length;
               mode_d      = mode;
               addr_d      = base_addr;
               idx_d       = '0;
               sorted_d    = 1'b0;
               inv_index_d = '0;
`ifdef ARRAY_ORDER_COUNT_EN
               count_d     = '0;
`endif
               if (length < LenTwo) begin
                  state_d  = DONE;
                  sorted_d = 1'b1;
               end else begin
                  state_d  = PRIME;
               end
            end
         end
         PRIME: begin
            // rd_data holds element 0 here.
            prev_d  = rd_data;
            idx_d   = LenOne;
            addr_d  = base_q + AddrOne;
            state_d = SCAN;
         end
         SCAN: begin
            prev_d = rd_data;
            idx_d  = idx_q + LenOne;
            // Address wraps modulo 2^ADDR_W; the read past the last element is ignored.
            addr_d = base_q + idx_q[ADDR_W-1:0] + AddrOne;
`ifdef ARRAY_ORDER_COUNT_EN
            if (inverted) begin
               count_d = count_q + LenOne;
               if (count_q == '0) begin
                  inv_index_d = idx_q;
               end
            end
            if (last_pair) begin
               state_d  = DONE;
               sorted_d = (count_d == '0);
            end
`else
            if (inverted) begin
               state_d     = DONE;
               sorted_d    = 1'b0;
               inv_index_d = idx_q;
            end else if (last_pair) begin
               state_d     = DONE;
               sorted_d    = 1'b1;
               inv_index_d = '0;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         base_q      <= '0;
         len_q       <= '0;
         mode_q      <= '0;
         prev_q      <= '0;
         idx_q       <= '0;
         sorted_q    <= 1'b0;
         inv_index_q <= '0;
         addr_q      <= '0;
`ifdef ARRAY_ORDER_COUNT_EN
         count_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         mode_q      <= mode_d;
         prev_q      <= prev_d;
         idx_q       <= idx_d;
         sorted_q    <= sorted_d;
         inv_index_q <= inv_index_d;
         addr_q      <= addr_d;
`ifdef ARRAY_ORDER_COUNT_EN
         count_q     <= count_d;
`endif
      end
   end

   // The address for the current cycle is presented combinationally (base on an accepted go).
   assign mem_addr  = addr_d;
   assign busy      = (state_q == PRIME) || (state_q == SCAN);
   assign done      = (state_q == DONE);
   assign sorted    = sorted_q;
   assign inv_index = inv_index_q;
`ifdef ARRAY_ORDER_COUNT_EN
   assign inv_count = count_q;
`endif

endmodule

// File: tb/tb_array_order_check.sv
// Directed testbench for array_order_check. Two instances share one memory model: one unsigned,
// one signed. Expected verdicts are queued when a scan is started and popped when done rises.
module tb_array_order_check;

   logic        clock;
   logic        reset;
   logic        go;
   logic [9:0]  base_addr;
   logic [10:0] length;
   logic [1:0]  mode;
   logic [9:0]  addr_u, addr_s;
   logic [31:0] rd_u, rd_s;
   logic        busy_u, busy_s, done_u, done_s, sorted_u, sorted_s;
   logic [10:0] idx_u, idx_s;
`ifdef ARRAY_ORDER_COUNT_EN
   logic [10:0] cnt_u, cnt_s;
`endif

   logic [31:0] mem [0:1023];

   array_order_check #(.DATA_W(32), .ADDR_W(10), .LEN_W(11), .SIGNED(0)) dut_u (
      .clock     (clock),
      .reset     (reset),
      .go        (go),
      .base_addr (base_addr),
      .length    (length),
      .mode      (mode),
      .mem_addr  (addr_u),
      .rd_data   (rd_u),
      .busy      (busy_u),
      .done      (done_u),
      .sorted    (sorted_u),
      .inv_index (idx_u)
`ifdef ARRAY_ORDER_COUNT_EN
      ,
      .inv_count (cnt_u)
`endif
   );

   array_order_check #(.DATA_W(32), .ADDR_W(10), .LEN_W(11), .SIGNED(1)) dut_s (
      .clock     (clock),
      .reset     (reset),
      .go        (go),
      .base_addr (base_addr),
      .length    (length),
      .mode      (mode),
      .mem_addr  (addr_s),
      .rd_data   (rd_s),
      .busy      (busy_s),
      .done      (done_s),
      .sorted    (sorted_s),
      .inv_index (idx_s)
`ifdef ARRAY_ORDER_COUNT_EN
      ,
      .inv_count (cnt_s)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      rd_u <= mem[addr_u];
      rd_s <= mem[addr_s];
   end

   // Selected instance for the current step.
   logic        use_s;
   logic        done_m, busy_m, sorted_m;
   logic [9:0]  addr_m;
   logic [10:0] idx_m;
   assign done_m   = use_s ? done_s   : done_u;
   assign busy_m   = use_s ? busy_s   : busy_u;
   assign sorted_m = use_s ? sorted_s : sorted_u;
   assign addr_m   = use_s ? addr_s   : addr_u;
   assign idx_m    = use_s ? idx_s    : idx_u;
`ifdef ARRAY_ORDER_COUNT_EN
   logic [10:0] cnt_m;
   assign cnt_m = use_s ? cnt_s : cnt_u;
`endif

   typedef struct {
      bit          sorted;
      logic [10:0] idx;
      int          lat;
      int          cnt;
   } exp_t;

   exp_t       exp_q[$];
   logic [9:0] addr_log[$];
   bit         busy_seen;
   int         n_vec;
   int         n_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Cycles from the go cycle until done is seen.
   function automatic int lat_of(input int n, input int k);
      if (n < 2) return 1;
`ifdef ARRAY_ORDER_COUNT_EN
      return n + 1;
`else
      return (k == 0) ? n + 1 : k + 2;
`endif
   endfunction

   task automatic run(input logic [9:0] b, input logic [10:0] n, input logic [1:0] m,
                      input bit exp_sorted, input logic [10:0] exp_idx, input int exp_cnt);
      exp_t e;
      int   lat;
      e.sorted = exp_sorted;
      e.idx    = exp_idx;
      e.lat    = lat_of(int'(n), int'(exp_idx));
      e.cnt    = exp_cnt;
      exp_q.push_back(e);
      addr_log.delete();
      busy_seen = 0;
      @(negedge clock);
      base_addr = b;
      length    = n;
      mode      = m;
      go        = 1'b1;
      #1;
      addr_log.push_back(addr_m);
      @(posedge clock);
      #1;
      go  = 1'b0;
      lat = 1;
      while (!done_m && lat < 300) begin
         if (busy_m) busy_seen = 1;
         addr_log.push_back(addr_m);
         @(posedge clock);
         #1;
         lat++;
      end
      e = exp_q.pop_front();
      check("done", 32'(done_m), 32'd1);
      check("latency", 32'(lat), 32'(e.lat));
      check("sorted", 32'(sorted_m), 32'(e.sorted));
      check("inv_index", 32'(idx_m), 32'(e.idx));
`ifdef ARRAY_ORDER_COUNT_EN
      check("inv_count", 32'(cnt_m), 32'(e.cnt));
`endif
      repeat (3) @(posedge clock);
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      use_s     = 1'b0;
      reset     = 1'b0;
      go        = 1'b0;
      base_addr = '0;
      length    = '0;
      mode      = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'(i);

      repeat (2) @(posedge clock);
      #1;
      check("rst_busy", 32'(busy_u), 32'd0);
      check("rst_done", 32'(done_u), 32'd0);
      check("rst_sorted", 32'(sorted_u), 32'd0);
      check("rst_inv_index", 32'(idx_u), 32'd0);
      check("rst_mem_addr", 32'(addr_u), 32'd0);
      @(negedge clock);
      reset = 1'b1;

      // Ascending non-strict, sorted.
      mem[16] = 1; mem[17] = 2; mem[18] = 2; mem[19] = 7; mem[20] = 9;
      run(10'h010, 11'd5, 2'b00, 1'b1, 11'd0, 0);

      // Inversion at index 3.
      mem[16] = 1; mem[17] = 3; mem[18] = 8; mem[19] = 4; mem[20] = 9;
      run(10'h010, 11'd5, 2'b00, 1'b0, 11'd3, 1);
      for (int i = 0; i < 5; i++) check("addr_seq", 32'(addr_log[i]), 32'(16 + i));

      // Degenerate lengths.
      run(10'h010, 11'd0, 2'b00, 1'b1, 11'd0, 0);
      check("len0_no_busy", 32'(busy_seen), 32'd0);
      run(10'h010, 11'd1, 2'b10, 1'b1, 11'd0, 0);
      check("len1_no_busy", 32'(busy_seen), 32'd0);

      // Descending strict and non-strict.
      mem[32] = 9; mem[33] = 5; mem[34] = 5; mem[35] = 1;
      run(10'h020, 11'd4, 2'b11, 1'b0, 11'd2, 1);
      run(10'h020, 11'd4, 2'b01, 1'b1, 11'd0, 0);

      // Signed ascending: sorted as two's complement, inverted at 2 when unsigned.
      mem[48] = 32'hFFFF_FFFD; mem[49] = 32'hFFFF_FFFF; mem[50] = 0; mem[51] = 2;
      use_s = 1'b1;
      run(10'h030, 11'd4, 2'b00, 1'b1, 11'd0, 0);
      use_s = 1'b0;
      check("unsigned_sorted", 32'(sorted_u), 32'd0);
      check("unsigned_inv_index", 32'(idx_u), 32'd2);

      // Address wrap at the top of memory.
      mem[1022] = 10; mem[1023] = 20; mem[0] = 30; mem[1] = 40;
      run(10'h3FE, 11'd4, 2'b00, 1'b1, 11'd0, 0);
      check("wrap_addr0", 32'(addr_log[0]), 32'h3FE);
      check("wrap_addr1", 32'(addr_log[1]), 32'h3FF);
      check("wrap_addr2", 32'(addr_log[2]), 32'h000);
      check("wrap_addr3", 32'(addr_log[3]), 32'h001);

      // Multiple inversions: first reported at 1, three in total.
      mem[64] = 5; mem[65] = 4; mem[66] = 3; mem[67] = 6; mem[68] = 1;
      run(10'h040, 11'd5, 2'b00, 1'b0, 11'd1, 3);

      // Reset in the middle of a scan.
      for (int i = 0; i < 8; i++) mem[256 + i] = 32'(100 + i);
      @(negedge clock);
      base_addr = 10'h100;
      length    = 11'd8;
      mode      = 2'b00;
      go        = 1'b1;
      @(posedge clock);
      #1;
      go = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("mid_busy", 32'(busy_u), 32'd1);
      reset = 1'b0;
      #1;
      check("abort_busy", 32'(busy_u), 32'd0);
      check("abort_done", 32'(done_u), 32'd0);
      check("abort_sorted", 32'(sorted_u), 32'd0);
      check("abort_inv_index", 32'(idx_u), 32'd0);
      check("abort_mem_addr", 32'(addr_u), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      run(10'h100, 11'd8, 2'b00, 1'b1, 11'd0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
